fpga_ram_gen: RTL and testbench

Parametrised single-port synchronous SRAM model for the FPGA fabric/user area: generic depth and word width, byte-lane write enables, an honoured port enable, selectable read-during-write mode, optional output pipeline register, and a post-reset clear sequencer. It is the successor to the fixed 128/256-word 32-bit RAM macros and serves as the behavioural stand-in for any hardened RAM in simulation and FPGA builds.

---
 rtl/fpga_ram_pkg.sv | 22 ++
 rtl/fpga_ram_clr.sv | 47 ++++
 rtl/fpga_ram_gen.sv | 123 ++++++++++++
 tb/tb_fpga_ram_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fpga_ram_pkg.sv
// Shared definitions for the generic single-port RAM: read-during-write modes,
// sequencer state encoding and the byte-lane merge helper.
package fpga_ram_pkg;

    localparam int unsigned RAM_WRITE_FIRST = 0;
    localparam int unsigned RAM_READ_FIRST  = 1;
    localparam int unsigned RAM_NO_CHANGE   = 2;

    typedef enum logic {
        RAM_CLR = 1'b0,
        RAM_RUN = 1'b1
    } ram_state_t;

    function automatic logic [7:0] ram_lane_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       we
    );
        return we ? new_b : old_b;
    endfunction

endpackage

// File: rtl/fpga_ram_clr.sv
// Post-reset clear sequencer: sweeps a pointer over every word once and holds
// the RAM busy until the last word has been zeroed.
module fpga_ram_clr
    import fpga_ram_pkg::*;
#(
    parameter int unsigned AW         = 8,
    parameter bit          CLR_ON_RST = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic          o_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);

    localparam logic [AW-1:0] LAST_WORD = '1;

    ram_state_t    r_state;
    ram_state_t    w_next;
    logic [AW-1:0] r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= CLR_ON_RST ? RAM_CLR : RAM_RUN;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == RAM_CLR) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == RAM_CLR && r_ptr == LAST_WORD) begin
            w_next = RAM_RUN;
        end
    end

    always_comb begin
        o_busy     = (r_state == RAM_CLR);
        o_clr_we   = (r_state == RAM_CLR);
        o_clr_addr = r_ptr;
    end

endmodule

// File: rtl/fpga_ram_gen.sv
// Parametrised single-port synchronous RAM with byte-lane writes, selectable
// read-during-write behaviour, optional output register and post-reset clear.
module fpga_ram_gen
    import fpga_ram_pkg::*;
#(
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 32,
    parameter int unsigned RD_MODE    = 0,
    parameter bit          OUT_REG    = 1'b0,
    parameter bit          CLR_ON_RST = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            VPWR,
    input  logic            VGND,
    input  logic            EN0,
    input  logic [AW-1:0]   A0,
    input  logic [DW-1:0]   Di0,
    input  logic [DW/8-1:0] WE0,
    output logic [DW-1:0]   Do0,
    output logic            Dv0,
    output logic            BUSY
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned NB    = DW / 8;

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_do;
    logic          r_dv;

    logic          w_busy;
    logic          w_clr_we;
    logic [AW-1:0] w_clr_addr;
    logic          w_accept;
    logic          w_wr;
    logic [DW-1:0] w_old;
    logic [DW-1:0] w_merged;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_data;
    logic          w_unused_pwr;

    fpga_ram_clr #(
        .AW         (AW),
        .CLR_ON_RST (CLR_ON_RST)
    ) u_clr (
        .i_clk      (CLK),
        .i_rst      (RST),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    always_comb begin
        w_old    = r_mem[A0];
        w_merged = w_old;
        for (int unsigned i = 0; i < NB; i++) begin
            w_merged[8*i +: 8] = ram_lane_merge(w_old[8*i +: 8], Di0[8*i +: 8], WE0[i]);
        end
    end

    // The clear sweep owns the array while busy; port accesses only land in RUN.
    always_comb begin
        w_accept     = EN0 & ~w_busy & ~RST;
        w_wr         = w_accept & (|WE0);
        w_mem_we     = (w_clr_we & ~RST) | w_wr;
        w_mem_addr   = w_clr_we ? w_clr_addr : A0;
        w_mem_data   = w_clr_we ? '0 : w_merged;
        w_unused_pwr = VPWR ^ VGND;
    end

    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_do <= '0;
            r_dv <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            if (w_accept) begin
                if (!w_wr) begin
                    r_do <= w_old;
                    r_dv <= 1'b1;
                end else if (RD_MODE == RAM_WRITE_FIRST) begin
                    r_do <= w_merged;
                    r_dv <= 1'b1;
                end else if (RD_MODE == RAM_READ_FIRST) begin
                    r_do <= w_old;
                    r_dv <= 1'b1;
                end
            end
        end
    end

    if (OUT_REG) begin : g_oreg
        logic [DW-1:0] r_do_q;
        logic          r_dv_q;

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_do_q <= '0;
                r_dv_q <= 1'b0;
            end else begin
                r_do_q <= r_do;
                r_dv_q <= r_dv;
            end
        end

        assign Do0 = r_do_q;
        assign Dv0 = r_dv_q;
    end else begin : g_noreg
        assign Do0 = r_do;
        assign Dv0 = r_dv;
    end

    assign BUSY = w_busy;

endmodule

// File: tb/tb_fpga_ram_gen.sv
// Directed bench for fpga_ram_gen: four instances share one stimulus stream
// (write-first, read-first, no-change, write-first with output register).
module tb_fpga_ram_gen;

    logic        CLK;
    logic        RST;
    logic        VPWR;
    logic        VGND;
    logic        EN0;
    logic [3:0]  A0;
    logic [31:0] Di0;
    logic [3:0]  WE0;

    logic [31:0] do_wf, do_rf, do_nc, do_or;
    logic        dv_wf, dv_rf, dv_nc, dv_or;
    logic        busy_wf, busy_rf, busy_nc, busy_or;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned nb;
    logic [31:0] exp_mem [16];
    logic [31:0] wdata;

    fpga_ram_gen #(.AW(4), .DW(32), .RD_MODE(0), .OUT_REG(1'b0), .CLR_ON_RST(1'b1)) u_wf (
        .CLK(CLK), .RST(RST), .VPWR(VPWR), .VGND(VGND), .EN0(EN0), .A0(A0),
        .Di0(Di0), .WE0(WE0), .Do0(do_wf), .Dv0(dv_wf), .BUSY(busy_wf)
    );
    fpga_ram_gen #(.AW(4), .DW(32), .RD_MODE(1), .OUT_REG(1'b0), .CLR_ON_RST(1'b1)) u_rf (
        .CLK(CLK), .RST(RST), .VPWR(VPWR), .VGND(VGND), .EN0(EN0), .A0(A0),
        .Di0(Di0), .WE0(WE0), .Do0(do_rf), .Dv0(dv_rf), .BUSY(busy_rf)
    );
    fpga_ram_gen #(.AW(4), .DW(32), .RD_MODE(2), .OUT_REG(1'b0), .CLR_ON_RST(1'b1)) u_nc (
        .CLK(CLK), .RST(RST), .VPWR(VPWR), .VGND(VGND), .EN0(EN0), .A0(A0),
        .Di0(Di0), .WE0(WE0), .Do0(do_nc), .Dv0(dv_nc), .BUSY(busy_nc)
    );
    fpga_ram_gen #(.AW(4), .DW(32), .RD_MODE(0), .OUT_REG(1'b1), .CLR_ON_RST(1'b1)) u_or (
        .CLK(CLK), .RST(RST), .VPWR(VPWR), .VGND(VGND), .EN0(EN0), .A0(A0),
        .Di0(Di0), .WE0(WE0), .Do0(do_or), .Dv0(dv_or), .BUSY(busy_or)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Counts sampled cycles with BUSY high, bounded so a stuck sequencer still ends.
    task automatic count_busy(output int unsigned n);
        n = 0;
        for (int i = 0; i < 40 && busy_wf; i++) begin
            n++;
            step();
        end
    endtask

    initial begin
        RST = 1'b1; EN0 = 1'b0; A0 = '0; Di0 = '0; WE0 = '0; VPWR = 1'b1; VGND = 1'b0;
        step();
        check("rst_do", do_wf, 32'h0);
        check("rst_dv", 32'(dv_wf), 32'd0);
        check("rst_busy", 32'(busy_wf), 32'd1);
        check("rst_do_or", do_or, 32'h0);
        RST = 1'b0;
        count_busy(nb);
        check("busy_len", nb, 32'd16);
        check("busy_or_low", 32'(busy_or), 32'd0);

        EN0 = 1'b1; WE0 = 4'h0;
        for (int a = 0; a < 16; a++) begin
            A0 = 4'(a);
            step();
            check("clr_rd_do", do_wf, 32'h0);
            check("clr_rd_dv", 32'(dv_wf), 32'd1);
        end

        A0 = 4'd3; Di0 = 32'hDEADBEEF; WE0 = 4'hF;
        step();
        check("w1_wf_do", do_wf, 32'hDEADBEEF);
        check("w1_rf_do", do_rf, 32'h0);
        WE0 = 4'h0;
        step();
        check("r1_nc_do", do_nc, 32'hDEADBEEF);
        check("r1_nc_dv", 32'(dv_nc), 32'd1);

        Di0 = 32'h11223344; WE0 = 4'b0101;
        step();
        check("w2_wf_do", do_wf, 32'hDE22BE44);
        check("w2_wf_dv", 32'(dv_wf), 32'd1);
        check("w2_rf_do", do_rf, 32'hDEADBEEF);
        check("w2_rf_dv", 32'(dv_rf), 32'd1);
        check("w2_nc_do", do_nc, 32'hDEADBEEF);
        check("w2_nc_dv", 32'(dv_nc), 32'd0);
        check("w2_or_do", do_or, 32'hDEADBEEF);
        WE0 = 4'h0;
        step();
        check("r2_wf_do", do_wf, 32'hDE22BE44);
        check("r2_rf_do", do_rf, 32'hDE22BE44);
        check("r2_nc_do", do_nc, 32'hDE22BE44);
        check("r2_or_do", do_or, 32'hDE22BE44);

        EN0 = 1'b0;
        step();
        step();
        check("idle_wf_dv", 32'(dv_wf), 32'd0);
        check("idle_or_dv", 32'(dv_or), 32'd0);
        check("idle_wf_hold", do_wf, 32'hDE22BE44);

        EN0 = 1'b1; A0 = 4'd3;
        step();
        check("lat1_wf_dv", 32'(dv_wf), 32'd1);
        check("lat1_or_dv", 32'(dv_or), 32'd0);
        EN0 = 1'b0;
        step();
        check("lat2_or_dv", 32'(dv_or), 32'd1);
        check("lat2_or_do", do_or, 32'hDE22BE44);
        check("lat2_wf_dv", 32'(dv_wf), 32'd0);

        WE0 = 4'hF; Di0 = 32'hFFFFFFFF;
        step();
        check("en0_wr_dv", 32'(dv_wf), 32'd0);
        check("en0_wr_do", do_wf, 32'hDE22BE44);
        EN0 = 1'b1; WE0 = 4'h0;
        step();
        check("en0_mem", do_wf, 32'hDE22BE44);

        EN0 = 1'b0; RST = 1'b1;
        step();
        RST = 1'b0; EN0 = 1'b1; A0 = 4'd2; WE0 = 4'hF; Di0 = 32'h12345678;
        for (int i = 0; i < 9; i++) step();
        check("busy_mid", 32'(busy_wf), 32'd1);
        check("busy_acc_dv", 32'(dv_wf), 32'd0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        count_busy(nb);
        check("busy_restart", nb, 32'd16);
        EN0 = 1'b1; WE0 = 4'h0; A0 = 4'd2;
        step();
        check("drop_wr_a2", do_wf, 32'h0);
        A0 = 4'd3;
        step();
        check("reclr_a3", do_wf, 32'h0);

        for (int a = 0; a < 16; a++) begin
            wdata      = 32'h9E3779B9 ^ (32'(a) * 32'h01010101);
            exp_mem[a] = (a % 2 == 1) ? (wdata & 32'hFF00FF00) : wdata;
            A0 = 4'(a); Di0 = wdata; WE0 = (a % 2 == 1) ? 4'b1010 : 4'hF;
            step();
            check("bw_wf_do", do_wf, exp_mem[a]);
            check("bw_rf_do", do_rf, 32'h0);
        end
        WE0 = 4'h0;
        for (int k = 0; k < 17; k++) begin
            A0 = 4'(k % 16);
            step();
            check("b2b_wf_dv", 32'(dv_wf), 32'd1);
            check("b2b_wf_do", do_wf, exp_mem[k % 16]);
            check("b2b_or_dv", 32'(dv_or), 32'd1);
            check("b2b_or_do", do_or, exp_mem[(k + 15) % 16]);
        end

        A0 = 4'd7; Di0 = 32'hCAFEF00D; WE0 = 4'hF;
        step();
        WE0 = 4'h0;
        step();
        check("wr_rd_wf", do_wf, 32'hCAFEF00D);
        check("wr_rd_rf", do_rf, 32'hCAFEF00D);
        EN0 = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
